// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and LFSR helper for the capture ready scheduler
package capture_pkg;

  typedef enum logic [1:0] {CAP_NONE, CAP_FULL, CAP_PERIODIC, CAP_RANDOM} capture_mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} cap_state_t;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR with seed loaded on reset; zero seed forced to 1
module lfsr16
  import capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;
  logic [15:0] seed_safe;

  assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

  always_comb begin
    q_d = q_q;
    if (step) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= seed_safe;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/capture_ready_scheduler.sv
// rtl/capture_ready_scheduler.sv - ready pattern generator, beat counter and end-of-capture FSM
module capture_ready_scheduler
  import capture_pkg::*;
#(
  parameter int          MODE         = 2,
  parameter int          ASSERT_CNT   = 5,
  parameter int          DEASSERT_CNT = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          RAND_THRESH  = 8,
  parameter int          EXPECT_BEATS = 0,
  parameter int          IDLE_TIMEOUT = 1000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        valid,
  output logic        ready,
  output logic        done,
  output logic        timeout,
  output logic        busy,
  output logic [31:0] beat_cnt
);

  localparam capture_mode_t MODE_E = capture_mode_t'(MODE[1:0]);
  localparam logic [31:0]   PERIOD = 32'(ASSERT_CNT + DEASSERT_CNT);
  localparam logic [31:0]   A_CNT  = 32'(ASSERT_CNT);
  localparam logic [31:0]   EXP    = 32'(EXPECT_BEATS);
  localparam logic [31:0]   TMO    = 32'(IDLE_TIMEOUT);
  localparam logic [15:0]   THRESH = 16'(RAND_THRESH);

  cap_state_t  state_q, state_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] phase_q, phase_d;
  logic [31:0] idle_q, idle_d;
  logic [15:0] lfsr_q;
  logic        lfsr_step;
  logic        beat;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign beat = valid && ready_q;

  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    beat_cnt_d = beat_cnt_q;
    phase_d    = phase_q;
    idle_d     = idle_q;
    lfsr_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_RUN;
          beat_cnt_d = '0;
          timeout_d  = 1'b0;
          phase_d    = '0;
          idle_d     = '0;
        end
      end
      ST_RUN: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
          idle_d     = '0;
        end else begin
          idle_d     = idle_q + 32'd1;
        end
        phase_d = (phase_q + 32'd1 >= PERIOD) ? '0 : phase_q + 32'd1;
        // Abort beats completion; completion beats timeout (timeout needs a beat-less cycle).
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (EXP != 32'd0 && beat && beat_cnt_d == EXP) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (TMO != 32'd0 && !beat && idle_q == TMO - 32'd1) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // ready is computed for the cycle being entered, so it drops the cycle after leaving RUN.
    if (state_d == ST_RUN) begin
      lfsr_step = 1'b1;
      case (MODE_E)
        CAP_NONE:     ready_d = 1'b0;
        CAP_FULL:     ready_d = 1'b1;
        CAP_PERIODIC: ready_d = (phase_d < A_CNT);
        CAP_RANDOM:   ready_d = ((lfsr_q & 16'h000F) < THRESH);
        default:      ready_d = 1'b0;
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
      phase_q    <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      phase_q    <= phase_d;
      idle_q     <= idle_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign busy     = busy_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_capture_ready_scheduler.sv
// tb/tb_capture_ready_scheduler.sv - directed self-checking bench for capture_ready_scheduler
module tb_capture_ready_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [6:0]  en;
  logic [6:0]  rdy, dn, tmo, bsy;
  logic [31:0] bc [7];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // 0 full/4 beats, 1 periodic 3/2, 2 none/timeout 8, 3..5 random thresh 8/0/16, 6 completion-vs-timeout race
  capture_ready_scheduler #(.MODE(1), .EXPECT_BEATS(4), .IDLE_TIMEOUT(0)) u_full (
    .clk(clk), .rst(rst), .enable(en[0]), .valid(valid), .ready(rdy[0]), .done(dn[0]),
    .timeout(tmo[0]), .busy(bsy[0]), .beat_cnt(bc[0]));
  capture_ready_scheduler #(.MODE(2), .ASSERT_CNT(3), .DEASSERT_CNT(2), .EXPECT_BEATS(0), .IDLE_TIMEOUT(0)) u_per (
    .clk(clk), .rst(rst), .enable(en[1]), .valid(valid), .ready(rdy[1]), .done(dn[1]),
    .timeout(tmo[1]), .busy(bsy[1]), .beat_cnt(bc[1]));
  capture_ready_scheduler #(.MODE(0), .EXPECT_BEATS(0), .IDLE_TIMEOUT(8)) u_none (
    .clk(clk), .rst(rst), .enable(en[2]), .valid(valid), .ready(rdy[2]), .done(dn[2]),
    .timeout(tmo[2]), .busy(bsy[2]), .beat_cnt(bc[2]));
  capture_ready_scheduler #(.MODE(3), .LFSR_SEED(16'hACE1), .RAND_THRESH(8), .IDLE_TIMEOUT(0)) u_rnd8 (
    .clk(clk), .rst(rst), .enable(en[3]), .valid(valid), .ready(rdy[3]), .done(dn[3]),
    .timeout(tmo[3]), .busy(bsy[3]), .beat_cnt(bc[3]));
  capture_ready_scheduler #(.MODE(3), .LFSR_SEED(16'hACE1), .RAND_THRESH(0), .IDLE_TIMEOUT(0)) u_rnd0 (
    .clk(clk), .rst(rst), .enable(en[4]), .valid(valid), .ready(rdy[4]), .done(dn[4]),
    .timeout(tmo[4]), .busy(bsy[4]), .beat_cnt(bc[4]));
  capture_ready_scheduler #(.MODE(3), .LFSR_SEED(16'hACE1), .RAND_THRESH(16), .IDLE_TIMEOUT(0)) u_rnd16 (
    .clk(clk), .rst(rst), .enable(en[5]), .valid(valid), .ready(rdy[5]), .done(dn[5]),
    .timeout(tmo[5]), .busy(bsy[5]), .beat_cnt(bc[5]));
  capture_ready_scheduler #(.MODE(1), .EXPECT_BEATS(3), .IDLE_TIMEOUT(3)) u_race (
    .clk(clk), .rst(rst), .enable(en[6]), .valid(valid), .ready(rdy[6]), .done(dn[6]),
    .timeout(tmo[6]), .busy(bsy[6]), .beat_cnt(bc[6]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({rdy[i], dn[i], tmo[i], bsy[i]} !== 4'b0000 || bc[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs inst %0d got r%b d%b t%b b%b cnt %0d expected all 0", i, rdy[i], dn[i], tmo[i], bsy[i], bc[i]);
      end
    end
    @(negedge clk) rst = 1'b0;
    tick();
    checks++;
    if (bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_enable got busy %b ready %b expected 0 0", bsy[0], rdy[0]);
    end
  endtask

  task automatic test_full();
    valid = 1'b1; en[0] = 1'b1;
    tick();
    checks++;
    if (rdy[0] !== 1'b1 || bsy[0] !== 1'b1 || bc[0] !== 32'd0) begin
      errors++;
      $display("FAIL full_first_run got ready %b busy %b cnt %0d expected 1 1 0", rdy[0], bsy[0], bc[0]);
    end
    repeat (3) tick();
    checks++;
    if (bc[0] !== 32'd3 || dn[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_mid got cnt %0d done %b expected 3 0", bc[0], dn[0]);
    end
    tick();
    checks++;
    if (dn[0] !== 1'b1 || bc[0] !== 32'd4 || rdy[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_done got done %b cnt %0d ready %b busy %b expected 1 4 0 0", dn[0], bc[0], rdy[0], bsy[0]);
    end
    tick();
    checks++;
    if (dn[0] !== 1'b0 || bc[0] !== 32'd4 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_after_done got done %b cnt %0d ready %b expected 0 4 0", dn[0], bc[0], rdy[0]);
    end
    en[0] = 1'b0;
    tick();
  endtask

  task automatic test_periodic();
    valid = 1'b1; en[1] = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rdy[1] !== ((k % 5) < 3)) begin
        errors++;
        $display("FAIL periodic_ready cycle %0d got %b expected %b", k, rdy[1], (k % 5) < 3);
      end
      tick();
    end
    checks++;
    if (bc[1] !== 32'd6) begin
      errors++;
      $display("FAIL periodic_beats got %0d expected 6", bc[1]);
    end
    en[1] = 1'b0;
    tick();
  endtask

  task automatic test_none_timeout();
    valid = 1'b1; en[2] = 1'b1;
    tick();
    repeat (7) tick();
    checks++;
    if (bsy[2] !== 1'b1 || dn[2] !== 1'b0) begin
      errors++;
      $display("FAIL none_before_timeout got busy %b done %b expected 1 0", bsy[2], dn[2]);
    end
    tick();
    checks++;
    if (dn[2] !== 1'b1 || tmo[2] !== 1'b1 || bc[2] !== 32'd0 || bsy[2] !== 1'b0) begin
      errors++;
      $display("FAIL none_timeout got done %b timeout %b cnt %0d busy %b expected 1 1 0 0", dn[2], tmo[2], bc[2], bsy[2]);
    end
    tick();
    checks++;
    if (dn[2] !== 1'b0 || tmo[2] !== 1'b1) begin
      errors++;
      $display("FAIL none_sticky got done %b timeout %b expected 0 1", dn[2], tmo[2]);
    end
    en[2] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] m;
    m = 16'hACE1;
    valid = 1'b1; en[5:3] = 3'b111;
    tick();
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (rdy[3] !== (m[3:0] < 4'd8)) begin
        errors++;
        $display("FAIL random_t8 cycle %0d got %b expected %b lfsr %h", k, rdy[3], m[3:0] < 4'd8, m);
      end
      checks++;
      if (rdy[4] !== 1'b0) begin
        errors++;
        $display("FAIL random_t0 cycle %0d got %b expected 0", k, rdy[4]);
      end
      checks++;
      if (rdy[5] !== 1'b1) begin
        errors++;
        $display("FAIL random_t16 cycle %0d got %b expected 1", k, rdy[5]);
      end
      m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
      tick();
    end
    en[5:3] = 3'b000;
    tick();
  endtask

  task automatic test_timeout_race();
    valid = 1'b1; en[6] = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    repeat (2) tick();
    valid = 1'b1;
    checks++;
    if (dn[6] !== 1'b0 || bsy[6] !== 1'b1 || bc[6] !== 32'd2) begin
      errors++;
      $display("FAIL race_pre got done %b busy %b cnt %0d expected 0 1 2", dn[6], bsy[6], bc[6]);
    end
    tick();
    checks++;
    if (dn[6] !== 1'b1 || tmo[6] !== 1'b0 || bc[6] !== 32'd3) begin
      errors++;
      $display("FAIL race_done got done %b timeout %b cnt %0d expected 1 0 3", dn[6], tmo[6], bc[6]);
    end
    en[6] = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    valid = 1'b1; en[1] = 1'b1;
    tick();
    repeat (7) tick();
    checks++;
    if (bc[1] !== 32'd5 || rdy[1] !== 1'b1 || bsy[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got cnt %0d ready %b busy %b expected 5 1 1", bc[1], rdy[1], bsy[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rdy[1], dn[1], tmo[1], bsy[1]} !== 4'b0000 || bc[1] !== 32'd0) begin
      errors++;
      $display("FAIL abort_rst got r%b d%b t%b b%b cnt %0d expected all 0", rdy[1], dn[1], tmo[1], bsy[1], bc[1]);
    end
    en[1] = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    en[1] = 1'b1;
    repeat (4) tick();
    en[1] = 1'b0;
    tick();
    checks++;
    if (bsy[1] !== 1'b0 || rdy[1] !== 1'b0 || bc[1] !== 32'd3) begin
      errors++;
      $display("FAIL disable_hold got busy %b ready %b cnt %0d expected 0 0 3", bsy[1], rdy[1], bc[1]);
    end
    en[1] = 1'b1;
    tick();
    checks++;
    if (bc[1] !== 32'd0 || bsy[1] !== 1'b1) begin
      errors++;
      $display("FAIL reenable_clear got cnt %0d busy %b expected 0 1", bc[1], bsy[1]);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rdy[1] !== (k < 3)) begin
        errors++;
        $display("FAIL reenable_phase cycle %0d got %b expected %b", k, rdy[1], k < 3);
      end
      tick();
    end
    en[1] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full();
    test_periodic();
    test_none_timeout();
    test_random();
    test_timeout_race();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t expected bench to finish earlier", $time);
    $fatal(1);
  end

endmodule
